// File: rtl/hazard5_instr_align_buf.sv
// Instruction fetch alignment buffer: queues word-aligned fetch data and
// presents a halfword-aligned 32-bit instruction window to the decompressor.
// Stale fetch data that returns after a jump is dropped.
module hazard5_instr_align_buf #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_addr_issue,
   input  logic        mem_data_vld,
   input  logic [31:0] mem_data,
   output logic        fetch_can_issue,
   input  logic        jump_now,
   input  logic        jump_target_hw,
   output logic [31:0] cir,
   output logic [1:0]  cir_vld,
   input  logic [1:0]  cir_use
);

   // Word FIFO as a flat shift register, entry 0 is the head
   logic [32*FIFO_DEPTH-1:0] fifo_q, fifo_d;
   logic [2:0]               fifo_cnt_q, fifo_cnt_d;
   // CIR: three halfword slots, slot 0 oldest; invalid slots are kept at zero
   logic [47:0]              cir_q, cir_d;
   logic [1:0]               cir_level_q, cir_level_d;
   logic [2:0]               outst_q, outst_d;
   logic [2:0]               discard_q, discard_d;
   logic                     hw_skip_q, hw_skip_d;

   logic        data_ok;
   logic [1:0]  level_after;
   logic [47:0] cir_shifted;
   logic [47:0] new_hw;
   logic [47:0] appended;
   logic [31:0] refill_word;
   logic        refill_want;
   logic        fifo_empty;
   logic        pop;
   logic        bypass;
   logic        push;
   logic [2:0]  push_idx;

   // Room for another request counts both buffered and in-flight words
   always_comb begin
      fetch_can_issue = ({1'b0, fifo_cnt_q} + {1'b0, outst_q}) < 4'(FIFO_DEPTH);
   end

   // Registered window; invalid slots already read as zero
   always_comb begin
      cir     = cir_q[31:0];
      cir_vld = (cir_level_q == 2'd3) ? 2'd2 : cir_level_q;
   end

   // Consume, refill, FIFO push/pop and bus bookkeeping
   always_comb begin
      data_ok     = mem_data_vld && (discard_q == 3'd0);
      level_after = cir_level_q - cir_use;

      unique case (cir_use)
         2'd0:    cir_shifted = cir_q;
         2'd1:    cir_shifted = {16'b0, cir_q[47:16]};
         2'd2:    cir_shifted = {32'b0, cir_q[47:32]};
         default: cir_shifted = '0;
      endcase

      refill_want = (level_after <= 2'd1);
      fifo_empty  = (fifo_cnt_q == 3'd0);
      pop         = refill_want && !fifo_empty;
      bypass      = refill_want && fifo_empty && data_ok;
      push        = data_ok && !bypass;
      refill_word = fifo_empty ? mem_data : fifo_q[31:0];

      // After a jump to an odd halfword only the upper half of the word is kept
      new_hw   = hw_skip_q ? {32'b0, refill_word[31:16]} : {16'b0, refill_word};
      appended = (level_after == 2'd0) ? new_hw : {new_hw[31:0], 16'b0};

      cir_d       = cir_shifted;
      cir_level_d = level_after;
      hw_skip_d   = hw_skip_q;
      if (pop || bypass) begin
         cir_d       = cir_shifted | appended;
         cir_level_d = level_after + (hw_skip_q ? 2'd1 : 2'd2);
         hw_skip_d   = 1'b0;
      end

      // Push lands just above whatever survives this cycle's pop
      push_idx   = fifo_cnt_q - {2'b0, pop};
      fifo_d     = pop ? (fifo_q >> 32) : fifo_q;
      fifo_cnt_d = fifo_cnt_q - {2'b0, pop};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (push && push_idx == 3'(i)) begin
            fifo_d[i*32 +: 32] = mem_data;
         end
      end
      if (push && push_idx < 3'(FIFO_DEPTH)) begin
         fifo_cnt_d = push_idx + 3'd1;
      end

      unique case ({mem_addr_issue, mem_data_vld})
         2'b10:   outst_d = outst_q + 3'd1;
         2'b01:   outst_d = (outst_q != 3'd0) ? outst_q - 3'd1 : 3'd0;
         default: outst_d = outst_q;
      endcase

      discard_d = discard_q;
      if (mem_data_vld && discard_q != 3'd0) begin
         discard_d = discard_q - 3'd1;
      end

      if (jump_now) begin
         // Everything in flight before the redirect is stale, including
         // data returning right now; an issue this cycle is for the new target
         cir_d       = '0;
         cir_level_d = 2'd0;
         fifo_d      = '0;
         fifo_cnt_d  = 3'd0;
         hw_skip_d   = jump_target_hw;
         discard_d   = (mem_data_vld && outst_q != 3'd0) ? outst_q - 3'd1 : outst_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q      <= '0;
         fifo_cnt_q  <= 3'd0;
         cir_q       <= '0;
         cir_level_q <= 2'd0;
         outst_q     <= 3'd0;
         discard_q   <= 3'd0;
         hw_skip_q   <= 1'b0;
      end else begin
         fifo_q      <= fifo_d;
         fifo_cnt_q  <= fifo_cnt_d;
         cir_q       <= cir_d;
         cir_level_q <= cir_level_d;
         outst_q     <= outst_d;
         discard_q   <= discard_d;
         hw_skip_q   <= hw_skip_d;
      end
   end

endmodule

// File: tb/tb_hazard5_instr_align_buf.sv
// Directed testbench for hazard5_instr_align_buf (FIFO_DEPTH = 2).
module tb_hazard5_instr_align_buf;

   logic        clk;
   logic        rst_n;
   logic        mem_addr_issue;
   logic        mem_data_vld;
   logic [31:0] mem_data;
   logic        fetch_can_issue;
   logic        jump_now;
   logic        jump_target_hw;
   logic [31:0] cir;
   logic [1:0]  cir_vld;
   logic [1:0]  cir_use;

   int passes = 0;
   int total  = 0;

   hazard5_instr_align_buf #(
      .FIFO_DEPTH(2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_addr_issue (mem_addr_issue),
      .mem_data_vld   (mem_data_vld),
      .mem_data       (mem_data),
      .fetch_can_issue(fetch_can_issue),
      .jump_now       (jump_now),
      .jump_target_hw (jump_target_hw),
      .cir            (cir),
      .cir_vld        (cir_vld),
      .cir_use        (cir_use)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iss, input logic vld, input logic [31:0] dat,
                        input logic [1:0] use_hw);
      mem_addr_issue = iss;
      mem_data_vld   = vld;
      mem_data       = dat;
      cir_use        = use_hw;
   endtask

   // Retiring more halfwords than are valid is illegal stimulus
   always @(negedge clk) begin
      if (rst_n && !jump_now) begin
         check("cir_use_legal", 32'(cir_use <= cir_vld), 32'd1);
      end
   end

   initial begin
      rst_n          = 1'b0;
      jump_now       = 1'b0;
      jump_target_hw = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 2'd0);
      #23;
      check("rst_cir", cir, 32'h0);
      check("rst_vld", 32'(cir_vld), 32'd0);
      check("rst_can", 32'(fetch_can_issue), 32'd1);
      rst_n = 1'b1;
      tick();

      // 1: sequential fill, A bypassed into CIR, B held in FIFO
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      check("t1_can_o1", 32'(fetch_can_issue), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      check("t1_can_o2", 32'(fetch_can_issue), 32'd0);
      drive(1'b0, 1'b1, 32'h00130513, 2'd0); tick();
      check("t1_cir_a", cir, 32'h00130513);
      check("t1_vld_a", 32'(cir_vld), 32'd2);
      drive(1'b0, 1'b1, 32'h00000001, 2'd0); tick();
      check("t1_cir_hold", cir, 32'h00130513);
      check("t1_can_b", 32'(fetch_can_issue), 32'd1);
      drive(1'b0, 1'b0, 32'h0, 2'd2); tick();
      check("t1_cir_b", cir, 32'h00000001);
      check("t1_vld_b", 32'(cir_vld), 32'd2);
      drive(1'b0, 1'b0, 32'h0, 2'd2); tick();
      check("t1_vld_empty", 32'(cir_vld), 32'd0);
      check("t1_cir_empty", cir, 32'h0);

      // 2: compressed stream
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b1, 32'h45014501, 2'd0); tick();
      check("t2_lo_0", 32'(cir[15:0]), 32'h4501);
      check("t2_vld_0", 32'(cir_vld), 32'd2);
      drive(1'b0, 1'b0, 32'h0, 2'd1); tick();
      check("t2_cir_1", cir, 32'h00004501);
      check("t2_vld_1", 32'(cir_vld), 32'd1);
      drive(1'b0, 1'b0, 32'h0, 2'd1); tick();
      check("t2_vld_2", 32'(cir_vld), 32'd0);

      // 3: 32-bit instruction straddling two words
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b1, 32'h05134501, 2'd0); tick();
      check("t3_cir_w0", cir, 32'h05134501);
      drive(1'b0, 1'b0, 32'h0, 2'd1); tick();
      check("t3_cir_half", cir, 32'h00000513);
      check("t3_vld_half", 32'(cir_vld), 32'd1);
      drive(1'b0, 1'b0, 32'h0, 2'd0); tick();
      check("t3_vld_wait", 32'(cir_vld), 32'd1);
      drive(1'b0, 1'b1, 32'h00000013, 2'd0); tick();
      check("t3_cir_join", cir, 32'h00130513);
      check("t3_vld_join", 32'(cir_vld), 32'd2);
      drive(1'b0, 1'b0, 32'h0, 2'd2); tick();
      check("t3_vld_left", 32'(cir_vld), 32'd1);
      check("t3_cir_left", cir, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 2'd1); tick();
      check("t3_vld_end", 32'(cir_vld), 32'd0);

      // 4: jump with two fetches outstanding, target on upper halfword
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0);
      jump_now = 1'b1; jump_target_hw = 1'b1; tick();
      jump_now = 1'b0; jump_target_hw = 1'b0;
      check("t4_vld_jump", 32'(cir_vld), 32'd0);
      check("t4_can_jump", 32'(fetch_can_issue), 32'd0);
      drive(1'b0, 1'b1, 32'h11111111, 2'd0); tick();
      check("t4_vld_stale1", 32'(cir_vld), 32'd0);
      check("t4_can_stale1", 32'(fetch_can_issue), 32'd1);
      drive(1'b0, 1'b1, 32'h22222222, 2'd0); tick();
      check("t4_vld_stale2", 32'(cir_vld), 32'd0);
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b1, 32'h8082AAAA, 2'd0); tick();
      check("t4_cir_new", cir, 32'h00008082);
      check("t4_vld_new", 32'(cir_vld), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b1, 32'h00010002, 2'd1); tick();
      check("t4_cir_noskip", cir, 32'h00010002);
      check("t4_vld_noskip", 32'(cir_vld), 32'd2);
      drive(1'b0, 1'b0, 32'h0, 2'd2); tick();

      // 5: jump coinciding with a return and a new issue
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b1, 32'h12345678, 2'd0); tick();
      check("t5_cir_pre", cir, 32'h12345678);
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b1, 1'b1, 32'hDEADBEEF, 2'd2);
      jump_now = 1'b1; tick();
      jump_now = 1'b0;
      check("t5_cir_jump", cir, 32'h0);
      check("t5_vld_jump", 32'(cir_vld), 32'd0);
      check("t5_can_jump", 32'(fetch_can_issue), 32'd0);
      drive(1'b0, 1'b1, 32'hBADBAD00, 2'd0); tick();
      check("t5_vld_drop", 32'(cir_vld), 32'd0);
      check("t5_can_drop", 32'(fetch_can_issue), 32'd1);
      drive(1'b0, 1'b1, 32'h00000073, 2'd0); tick();
      check("t5_cir_new", cir, 32'h00000073);
      check("t5_vld_new", 32'(cir_vld), 32'd2);
      drive(1'b0, 1'b0, 32'h0, 2'd2); tick();

      // 6: back-pressure with no retirement, then drain in order
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      check("t6_can_o1", 32'(fetch_can_issue), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      check("t6_can_o2", 32'(fetch_can_issue), 32'd0);
      drive(1'b0, 1'b1, 32'hAAAA0001, 2'd0); tick();
      check("t6_cir_w1", cir, 32'hAAAA0001);
      check("t6_can_w1", 32'(fetch_can_issue), 32'd1);
      drive(1'b1, 1'b1, 32'hBBBB0002, 2'd0); tick();
      check("t6_can_w2", 32'(fetch_can_issue), 32'd0);
      check("t6_cir_w2", cir, 32'hAAAA0001);
      drive(1'b0, 1'b1, 32'hCCCC0003, 2'd0); tick();
      check("t6_can_full", 32'(fetch_can_issue), 32'd0);
      drive(1'b0, 1'b0, 32'h0, 2'd1); tick();
      check("t6_cir_pop1", cir, 32'h0002AAAA);
      check("t6_can_pop1", 32'(fetch_can_issue), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      check("t6_can_o3", 32'(fetch_can_issue), 32'd0);
      drive(1'b0, 1'b1, 32'hDDDD0004, 2'd0); tick();
      check("t6_cir_l3full", cir, 32'h0002AAAA);
      check("t6_can_l3full", 32'(fetch_can_issue), 32'd0);
      drive(1'b0, 1'b0, 32'h0, 2'd2); tick();
      check("t6_cir_pop2", cir, 32'h0003BBBB);
      drive(1'b0, 1'b0, 32'h0, 2'd2); tick();
      check("t6_cir_pop3", cir, 32'h0004CCCC);
      check("t6_can_pop3", 32'(fetch_can_issue), 32'd1);
      drive(1'b0, 1'b0, 32'h0, 2'd2); tick();
      check("t6_cir_last", cir, 32'h0000DDDD);
      check("t6_vld_last", 32'(cir_vld), 32'd1);
      drive(1'b0, 1'b0, 32'h0, 2'd1); tick();
      check("t6_vld_end", 32'(cir_vld), 32'd0);

      // Asynchronous reset in the middle of a transfer
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b1, 1'b1, 32'h11112222, 2'd0); tick();
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0);
      #2 rst_n = 1'b0;
      #1;
      check("ar_cir", cir, 32'h0);
      check("ar_vld", 32'(cir_vld), 32'd0);
      check("ar_can", 32'(fetch_can_issue), 32'd1);
      rst_n = 1'b1;
      tick();
      // Reset taken with a discard count and hw_skip pending
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0);
      jump_now = 1'b1; jump_target_hw = 1'b1; tick();
      jump_now = 1'b0; jump_target_hw = 1'b0;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 2'd0); tick();
      drive(1'b0, 1'b1, 32'h00000013, 2'd0); tick();
      check("ar_cir_post", cir, 32'h00000013);
      check("ar_vld_post", 32'(cir_vld), 32'd2);
      drive(1'b0, 1'b0, 32'h0, 2'd0); tick();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
